// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war referee: FSM states, winner codes,
// score width and the saturating score increment.
package tow_pkg;

  localparam int SCORE_W = 3;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    PLAY = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_L    = 2'b10;
  localparam winner_t WIN_R    = 2'b01;

  // Increments a score but never beyond the match-ending limit.
  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] val,
    input logic [SCORE_W-1:0] lim
  );
    logic [SCORE_W-1:0] res;
    if (val >= lim) begin
      res = val;
    end else begin
      res = val + {{(SCORE_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/tug_referee_if.sv
// Player keys, playfield status/commands and score display bundled together.
interface tug_referee_if;
  import tow_pkg::*;

  logic               key_l;
  logic               key_r;
  logic               edge_l;
  logic               edge_r;
  logic               move_l;
  logic               move_r;
  logic               field_reset;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [1:0]         winner;
  logic               match_over;

  modport master (
    input  key_l, key_r, edge_l, edge_r,
    output move_l, move_r, field_reset, score_l, score_r, winner, match_over
  );

  modport slave (
    output key_l, key_r, edge_l, edge_r,
    input  move_l, move_r, field_reset, score_l, score_r, winner, match_over
  );

endinterface

// File: rtl/key_pulse.sv
// Two-flop synchronizer plus rising-edge detector: one registered pulse per
// press, three clock edges after the key goes high.
module key_pulse (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic pulse_r;

  // Synchronize the asynchronous key and register its rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      pulse_r <= sync2_r & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/tug_referee_chk.sv
// Simulation-only safety properties on the referee outputs.
module tug_referee_chk
  import tow_pkg::*;
#(
  parameter int WIN_SCORE = 7
) (
  input logic               clock,
  input logic               reset,
  input logic               move_l,
  input logic               move_r,
  input logic               field_reset,
  input logic [SCORE_W-1:0] score_l,
  input logic [SCORE_W-1:0] score_r,
  input logic               match_over
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  a_moves_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(move_l && move_r));

  a_score_l_sat: assert property (@(posedge clock) disable iff (reset)
    score_l <= WIN_VAL);

  a_score_r_sat: assert property (@(posedge clock) disable iff (reset)
    score_r <= WIN_VAL);

  a_recentre_quiet: assert property (@(posedge clock) disable iff (reset)
    field_reset |-> !(move_l || move_r));

  a_over_quiet: assert property (@(posedge clock) disable iff (reset)
    match_over |-> !(move_l || move_r || field_reset));

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: turns key presses into playfield moves, scores points
// when the light is pulled off an edge, and ends the match at WIN_SCORE.
module tug_referee
  import tow_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int WIN_SCORE   = 7
) (
  input  logic          clock,
  input  logic          reset,
  tug_referee_if.master bus
);

  localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  logic               req_l_s;
  logic               req_r_s;

  state_t             state_r;
  state_t             state_s;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [HOLD_W-1:0]  hold_cnt_s;
  logic [SCORE_W-1:0] score_l_r;
  logic [SCORE_W-1:0] score_l_s;
  logic [SCORE_W-1:0] score_r_r;
  logic [SCORE_W-1:0] score_r_s;
  winner_t            winner_r;
  winner_t            winner_s;
  logic               over_r;
  logic               over_s;
  logic               move_l_s;
  logic               move_r_s;
  logic               field_reset_s;

  key_pulse u_key_l (
    .clock (clock),
    .reset (reset),
    .key   (bus.key_l),
    .pulse (req_l_s)
  );

  key_pulse u_key_r (
    .clock (clock),
    .reset (reset),
    .key   (bus.key_r),
    .pulse (req_r_s)
  );

  // State, hold counter, scores and winner registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= INIT;
      hold_cnt_r <= '0;
      score_l_r  <= '0;
      score_r_r  <= '0;
      winner_r   <= WIN_NONE;
      over_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      score_l_r  <= score_l_s;
      score_r_r  <= score_r_s;
      winner_r   <= winner_s;
      over_r     <= over_s;
    end
  end

  // Next-state, scoring and playfield command decode.
  always_comb begin
    state_s       = state_r;
    hold_cnt_s    = hold_cnt_r;
    score_l_s     = score_l_r;
    score_r_s     = score_r_r;
    winner_s      = winner_r;
    over_s        = over_r;
    move_l_s      = 1'b0;
    move_r_s      = 1'b0;
    field_reset_s = 1'b0;

    case (state_r)
      INIT: begin
        field_reset_s = 1'b1;
        winner_s      = WIN_NONE;
        hold_cnt_s    = '0;
        state_s       = PLAY;
      end

      PLAY: begin
        move_l_s   = req_l_s & ~req_r_s;
        move_r_s   = req_r_s & ~req_l_s;
        hold_cnt_s = '0;
        // The move still goes out on the scoring cycle; the edge only counts
        // when it matches the direction being pulled.
        if (move_l_s && bus.edge_l) begin
          score_l_s = sat_inc(score_l_r, WIN_VAL);
          winner_s  = WIN_L;
          state_s   = SHOW;
        end else if (move_r_s && bus.edge_r) begin
          score_r_s = sat_inc(score_r_r, WIN_VAL);
          winner_s  = WIN_R;
          state_s   = SHOW;
        end else begin
          state_s = PLAY;
        end
      end

      SHOW: begin
        if (hold_cnt_r == HOLD_LAST) begin
          hold_cnt_s = '0;
          if ((score_l_r == WIN_VAL) || (score_r_r == WIN_VAL)) begin
            over_s  = 1'b1;
            state_s = OVER;
          end else begin
            winner_s = WIN_NONE;
            state_s  = INIT;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end

      OVER: begin
        over_s  = 1'b1;
        state_s = OVER;
      end

      default: begin
        winner_s = WIN_NONE;
        over_s   = 1'b0;
        state_s  = INIT;
      end
    endcase
  end

  // INIT is the reset state, so the re-centre pulse is held off until reset
  // is released to keep it to exactly one cycle.
  assign bus.field_reset = field_reset_s & ~reset;
  assign bus.move_l      = move_l_s & ~reset;
  assign bus.move_r      = move_r_s & ~reset;
  assign bus.score_l     = score_l_r;
  assign bus.score_r     = score_r_r;
  assign bus.winner      = winner_r;
  assign bus.match_over  = over_r;

  tug_referee_chk #(
    .WIN_SCORE (WIN_SCORE)
  ) u_chk (
    .clock       (clock),
    .reset       (reset),
    .move_l      (bus.move_l),
    .move_r      (bus.move_r),
    .field_reset (bus.field_reset),
    .score_l     (bus.score_l),
    .score_r     (bus.score_r),
    .match_over  (bus.match_over)
  );

endmodule

// File: tb/tb_tug_referee.sv
// Directed, table-driven bench for tug_referee (HOLD_CYCLES=4, WIN_SCORE=7).
module tb_tug_referee;

  typedef struct {
    logic [3:0]  in;   // {key_l, key_r, edge_l, edge_r}
    logic [11:0] exp;  // {move_l, move_r, field_reset, score_l, score_r, winner, match_over}
  } vec_t;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  tug_referee_if bus ();

  tug_referee #(
    .HOLD_CYCLES (4),
    .WIN_SCORE   (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [3:0] in, input logic [2:0] mv,
                              input logic [2:0] sl, input logic [2:0] sr,
                              input logic [1:0] w, input logic mo);
    vec_t v;
    v.in  = in;
    v.exp = {mv, sl, sr, w, mo};
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {bus.move_l, bus.move_r, bus.field_reset, bus.score_l, bus.score_r,
            bus.winner, bus.match_over};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got ml,mr,fr=%b sl=%0d sr=%0d w=%b mo=%b, expected ml,mr,fr=%b sl=%0d sr=%0d w=%b mo=%b",
               name, act[11:9], act[8:6], act[5:3], act[2:1], act[0],
               req[11:9], req[8:6], req[5:3], req[2:1], req[0]);
    end
  endtask

  task automatic step(input logic [3:0] in);
    {bus.key_l, bus.key_r, bus.edge_l, bus.edge_r} = in;
    @(posedge clock);
    #1;
  endtask

  vec_t vecs [36];
  int   pulses;
  int   pulse_at;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    {bus.key_l, bus.key_r, bus.edge_l, bus.edge_r} = 4'b0000;

    vecs[0]  = mk(4'b1000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[1]  = mk(4'b1000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[2]  = mk(4'b1000, 3'b100, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[3]  = mk(4'b0000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[4]  = mk(4'b0100, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[5]  = mk(4'b0100, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[6]  = mk(4'b0100, 3'b010, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[7]  = mk(4'b0000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[8]  = mk(4'b1100, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[9]  = mk(4'b1100, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[10] = mk(4'b1100, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[11] = mk(4'b0000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[12] = mk(4'b0000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[13] = mk(4'b0110, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[14] = mk(4'b0110, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[15] = mk(4'b0110, 3'b010, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[16] = mk(4'b0010, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[17] = mk(4'b0000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[18] = mk(4'b1000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[19] = mk(4'b1000, 3'b000, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[20] = mk(4'b1000, 3'b100, 3'd0, 3'd0, 2'b00, 1'b0);
    vecs[21] = mk(4'b1010, 3'b000, 3'd1, 3'd0, 2'b10, 1'b0);
    vecs[22] = mk(4'b1110, 3'b000, 3'd1, 3'd0, 2'b10, 1'b0);
    vecs[23] = mk(4'b1110, 3'b000, 3'd1, 3'd0, 2'b10, 1'b0);
    vecs[24] = mk(4'b1010, 3'b000, 3'd1, 3'd0, 2'b10, 1'b0);
    vecs[25] = mk(4'b0000, 3'b001, 3'd1, 3'd0, 2'b00, 1'b0);
    vecs[26] = mk(4'b0000, 3'b000, 3'd1, 3'd0, 2'b00, 1'b0);
    vecs[27] = mk(4'b0100, 3'b000, 3'd1, 3'd0, 2'b00, 1'b0);
    vecs[28] = mk(4'b0100, 3'b000, 3'd1, 3'd0, 2'b00, 1'b0);
    vecs[29] = mk(4'b0100, 3'b010, 3'd1, 3'd0, 2'b00, 1'b0);
    vecs[30] = mk(4'b0001, 3'b000, 3'd1, 3'd1, 2'b01, 1'b0);
    vecs[31] = mk(4'b0000, 3'b000, 3'd1, 3'd1, 2'b01, 1'b0);
    vecs[32] = mk(4'b0000, 3'b000, 3'd1, 3'd1, 2'b01, 1'b0);
    vecs[33] = mk(4'b0000, 3'b000, 3'd1, 3'd1, 2'b01, 1'b0);
    vecs[34] = mk(4'b0000, 3'b001, 3'd1, 3'd1, 2'b00, 1'b0);
    vecs[35] = mk(4'b0000, 3'b000, 3'd1, 3'd1, 2'b00, 1'b0);

    // Reset and release: one re-centre pulse, then PLAY.
    step(4'b0000);
    step(4'b0000);
    chk("reset_state", obs(), 12'b000_000_000_00_0);
    reset = 1'b0;
    #1;
    chk("init_pulse", obs(), 12'b001_000_000_00_0);
    step(4'b0000);
    chk("play_entry", obs(), 12'b000_000_000_00_0);

    for (int i = 0; i < 36; i++) begin
      step(vecs[i].in);
      chk($sformatf("row%0d", i), obs(), vecs[i].exp);
    end

    // Remaining left points up to the match-ending seventh.
    for (int p = 2; p <= 7; p++) begin
      step(4'b1000);
      step(4'b1000);
      step(4'b1000);
      chk($sformatf("pt%0d_move", p), obs(), {3'b100, 3'(p - 1), 3'd1, 2'b00, 1'b0});
      step(4'b0010);
      chk($sformatf("pt%0d_score", p), obs(), {3'b000, 3'(p), 3'd1, 2'b10, 1'b0});
      for (int k = 0; k < 4; k++) step(4'b0000);
      if (p < 7) begin
        chk($sformatf("pt%0d_recentre", p), obs(), {3'b001, 3'(p), 3'd1, 2'b00, 1'b0});
        step(4'b0000);
      end else begin
        chk("match_over", obs(), {3'b000, 3'd7, 3'd1, 2'b10, 1'b1});
      end
    end

    // Presses and edges after the match change nothing.
    for (int k = 0; k < 8; k++) begin
      step((k < 5) ? 4'b1011 : 4'b0111);
      chk($sformatf("over_hold%0d", k), obs(), {3'b000, 3'd7, 3'd1, 2'b10, 1'b1});
    end

    // Reset out of OVER, then score and abort two cycles into SHOW.
    reset = 1'b1;
    step(4'b0000);
    chk("reset_from_over", obs(), 12'b000_000_000_00_0);
    reset = 1'b0;
    #1;
    chk("init_after_over", obs(), 12'b001_000_000_00_0);
    step(4'b0000);
    step(4'b1000);
    step(4'b1000);
    step(4'b1000);
    step(4'b0010);
    chk("show_score", obs(), {3'b000, 3'd1, 3'd0, 2'b10, 1'b0});
    step(4'b0000);
    step(4'b0000);
    reset = 1'b1;
    step(4'b0000);
    chk("reset_mid_show", obs(), 12'b000_000_000_00_0);
    reset = 1'b0;
    #1;
    chk("init_after_show", obs(), 12'b001_000_000_00_0);
    step(4'b0000);
    chk("play_after_show", obs(), 12'b000_000_000_00_0);

    // Long hold: exactly one move_l, on the third edge after the press.
    pulses   = 0;
    pulse_at = -1;
    for (int k = 0; k < 20; k++) begin
      step(4'b1000);
      if (bus.move_l === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
    end
    chk("hold_pulse_count", 12'(pulses), 12'd1);
    chk("hold_pulse_cycle", 12'(pulse_at), 12'd2);
    step(4'b0000);
    chk("hold_release", obs(), 12'b000_000_000_00_0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
